// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 codes and access-legality helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_H, F3_HU: return !lane[0];
            F3_W:        return lane == 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    // Byte-lane write enables within the 32-bit word, for stores only.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return 4'b0011 << lane;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// rtl/lsu_load_ext.sv - selects the addressed byte/half of a RAM word and sign/zero-extends it
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = word;
            F3_BU:   data = {24'b0, shifted[7:0]};
            F3_HU:   data = {16'b0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_data_mem.sv
// rtl/lsu_data_mem.sv - byte-addressable data RAM with programmable latency and RV32I load/store handshake
module lsu_data_mem
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err
);

    lsu_state_t state, next_state;

    logic [3:0]               cnt;
    logic                     l_we;
    logic [2:0]               l_funct3;
    logic [ADDRESS_WIDTH-1:0] l_addr;
    logic [DATA_WIDTH-1:0]    l_wdata;

    logic [7:0] mem [2**ADDRESS_WIDTH];

    logic        accept;
    logic        req_ok;
    logic        commit;
    logic [31:0] rd_word;
    logic [31:0] load_data;
    logic [31:0] wdata_sh;
    logic [3:0]  wmask;

    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign req_ok     = is_legal(req_we, req_funct3) && is_aligned(req_funct3, req_addr[1:0]);
    assign commit     = (state == WAIT) && (cnt == 4'd0);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = req_ok ? WAIT : RESP;
            WAIT:    if (cnt == 4'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            l_we       <= 1'b0;
            l_funct3   <= '0;
            l_addr     <= '0;
            l_wdata    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    l_we     <= req_we;
                    l_funct3 <= req_funct3;
                    l_addr   <= req_addr;
                    l_wdata  <= req_wdata;
                    if (req_ok) begin
                        cnt <= 4'(MEM_LATENCY - 1);
                    end else begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                WAIT: if (cnt == 4'd0) begin
                    resp_err   <= 1'b0;
                    resp_rdata <= l_we ? '0 : load_data;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Aligned accesses stay inside one word, so lanes index from the word base.
    assign rd_word = {mem[{l_addr[ADDRESS_WIDTH-1:2], 2'd3}], mem[{l_addr[ADDRESS_WIDTH-1:2], 2'd2}],
                      mem[{l_addr[ADDRESS_WIDTH-1:2], 2'd1}], mem[{l_addr[ADDRESS_WIDTH-1:2], 2'd0}]};
    assign wdata_sh = l_wdata << {l_addr[1:0], 3'b000};
    assign wmask    = lane_mask(l_funct3, l_addr[1:0]);

    always_ff @(posedge clk) begin
        if (!rst && commit && l_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[{l_addr[ADDRESS_WIDTH-1:2], 2'(i)}] <= wdata_sh[8*i +: 8];
            end
        end
    end

    lsu_load_ext u_load_ext (
        .word   (rd_word),
        .lane   (l_addr[1:0]),
        .funct3 (l_funct3),
        .data   (load_data)
    );

endmodule

// File: tb/tb_lsu_data_mem.sv
// tb/tb_lsu_data_mem.sv - scoreboard bench for lsu_data_mem
module tb_lsu_data_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    lsu_data_mem #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input string name);
        exp_t e;
        int   lat;
        bit   acc;
        bit   got;
        bit   ready_leak;
        exp_q.push_back('{exp_rdata, exp_err, exp_lat});
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (req_ready) acc = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL %s accept: req_ready got 0 expected 1", name);
            req_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'($urandom);
        req_addr = 16'($urandom); req_wdata = $urandom;
        lat = 0; got = 1'b0; ready_leak = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1'b1;
            else if (req_ready) ready_leak = 1'b1;
        end
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s timeout: resp_valid got 0 expected 1", name);
            return;
        end
        total++;
        if (resp_rdata !== e.rdata) begin
            bad++;
            $display("FAIL %s rdata: got %h expected %h", name, resp_rdata, e.rdata);
        end
        total++;
        if (resp_err !== e.err) begin
            bad++;
            $display("FAIL %s err: got %b expected %b", name, resp_err, e.err);
        end
        total++;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
        end
        total++;
        if (ready_leak !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_ready: got %b expected 0", name, ready_leak);
        end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s after_resp: valid/ready got %b%b expected 01", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset: ready/valid/err got %b%b%b rdata %h expected 000 rdata 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: req_ready got %b expected 1", req_ready);
        end
    endtask

    task automatic test_word_and_subword();
        do_req(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 3, "sw_10");
        do_req(1'b0, 3'b010, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 3, "lw_10");
        do_req(1'b0, 3'b000, 16'h0013, 32'h0, 32'hFFFFFFDE, 1'b0, 3, "lb_13");
        do_req(1'b0, 3'b100, 16'h0013, 32'h0, 32'h000000DE, 1'b0, 3, "lbu_13");
        do_req(1'b0, 3'b001, 16'h0012, 32'h0, 32'hFFFFDEAD, 1'b0, 3, "lh_12");
        do_req(1'b0, 3'b101, 16'h0010, 32'h0, 32'h0000BEEF, 1'b0, 3, "lhu_10");
        do_req(1'b1, 3'b000, 16'h0011, 32'hAABBCC55, 32'h0, 1'b0, 3, "sb_11");
        do_req(1'b0, 3'b010, 16'h0010, 32'h0, 32'hDEAD55EF, 1'b0, 3, "lw_after_sb");
    endtask

    task automatic test_errors();
        do_req(1'b0, 3'b010, 16'h0012, 32'h0, 32'h0, 1'b1, 1, "lw_misaligned");
        do_req(1'b1, 3'b001, 16'h0011, 32'h00001234, 32'h0, 1'b1, 1, "sh_misaligned");
        do_req(1'b0, 3'b010, 16'h0010, 32'h0, 32'hDEAD55EF, 1'b0, 3, "lw_after_bad_sh");
        do_req(1'b0, 3'b011, 16'h0010, 32'h0, 32'h0, 1'b1, 1, "load_f3_011");
        do_req(1'b1, 3'b011, 16'h0010, 32'hFFFFFFFF, 32'h0, 1'b1, 1, "store_f3_011");
        do_req(1'b1, 3'b100, 16'h0010, 32'hFFFFFFFF, 32'h0, 1'b1, 1, "store_f3_100");
        do_req(1'b0, 3'b001, 16'h0011, 32'h0, 32'h0, 1'b1, 1, "lh_misaligned");
        do_req(1'b0, 3'b010, 16'h0010, 32'h0, 32'hDEAD55EF, 1'b0, 3, "lw_after_bad_stores");
    endtask

    task automatic test_top_of_ram();
        do_req(1'b1, 3'b010, 16'hFFFC, 32'hCAFEF00D, 32'h0, 1'b0, 3, "sw_top");
        do_req(1'b0, 3'b000, 16'hFFFF, 32'h0, 32'hFFFFFFCA, 1'b0, 3, "lb_top");
        do_req(1'b0, 3'b101, 16'hFFFE, 32'h0, 32'h0000CAFE, 1'b0, 3, "lhu_top");
    endtask

    task automatic test_reset_mid();
        int  pulses;
        bit  acc;
        do_req(1'b1, 3'b010, 16'h0020, 32'hA5A5A5A5, 32'h0, 1'b0, 3, "sw_20_old");
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 16'h0020; req_wdata = 32'h12345678;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (req_ready) acc = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_state: valid/ready got %b%b expected 00", resp_valid, req_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_idle: req_ready got %b expected 1", req_ready);
        end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL mid_reset_pulses: got %0d expected 0", pulses);
        end
        do_req(1'b0, 3'b010, 16'h0020, 32'h0, 32'hA5A5A5A5, 1'b0, 3, "lw_20_after_reset");
    endtask

    task automatic test_back_to_back();
        int  accepts;
        int  resps;
        bit  prev_ready;
        bit  overlap;
        exp_t e;
        accepts = 0; resps = 0; prev_ready = 1'b0; overlap = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0010; req_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            if (req_ready && (resp_valid || prev_ready)) overlap = 1'b1;
            if (req_ready) begin
                accepts++;
                exp_q.push_back('{32'hDEAD55EF, 1'b0, 3});
            end
            if (resp_valid) begin
                resps++;
                e = exp_q.pop_front();
                total++;
                if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                    bad++;
                    $display("FAIL b2b_data: got %h/%b expected %h/%b", resp_rdata, resp_err, e.rdata, e.err);
                end
            end
            prev_ready = req_ready;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) begin
                resps++;
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        total++;
        if (accepts !== 4) begin
            bad++;
            $display("FAIL b2b_accepts: got %0d expected 4", accepts);
        end
        total++;
        if (resps !== accepts) begin
            bad++;
            $display("FAIL b2b_responses: got %0d expected %0d", resps, accepts);
        end
        total++;
        if (overlap !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_busy: got %b expected 0", overlap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_and_subword();
        test_errors();
        test_top_of_ram();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
